top_fetch: RTL and testbench

//  Fetch stage feeding the decode stage of the 5-stage RV32I pipeline.
//  - Owns the PC register and drives the instruction-memory address; imem is external, combinational read.
//  - Selects PC+4 or the execute-stage redirect target.
//  - Holds the IF/ID pipeline register (instr_D, PC_D, PCplus4_D, valid_D) consumed by top_decode.
//  - Obeys stall/flush from the hazard unit and keeps a fetch counter for performance checks.

---
 rtl/rv_pkg.sv | 13 +
 rtl/top_fetch_if_id_reg.sv | 41 ++++
 rtl/top_fetch.sv | 85 ++++++++
 tb/tb_top_fetch.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants and types for the RV32I pipeline front end.
package rv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/top_fetch_if_id_reg.sv
// IF/ID pipeline register: clear inserts a bubble and wins over enable.
module if_id_reg
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] instr_f,
  input  logic [WIDTH-1:0] pc_f,
  input  logic [WIDTH-1:0] pc_plus4_f,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d
);

  localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_INSTR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d    <= BUBBLE;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (clr) begin
      instr_d    <= BUBBLE;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (en) begin
      instr_d    <= instr_f;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: rtl/top_fetch.sv
// Fetch stage: PC register, next-PC selection, boot FSM, fetch counter and IF/ID register.
module top_fetch
  import rv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_F,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic             PCsrc_E,
  input  logic [WIDTH-1:0] PCtarget_E,
  input  logic [WIDTH-1:0] instr_F,
  output logic [WIDTH-1:0] PC_F,
  output logic [WIDTH-1:0] instr_D,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PCplus4_D,
  output logic             valid_D,
  output logic [WIDTH-1:0] fetch_count
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  fetch_state_t     state;
  logic             boot;
  logic             capture;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] target_aligned;
  logic [WIDTH-1:0] pc_next;

  assign boot           = (state == BOOT);
  assign capture        = !boot && !flush_D && !stall_D;
  assign pc_plus4       = PC_F + WIDTH'(4);
  assign target_aligned = PCtarget_E & ALIGN_MASK;

  // A resolved redirect beats a fetch stall so the wrong path is never re-fetched.
  always_comb begin
    pc_next = pc_plus4;
    if (PCsrc_E)
      pc_next = target_aligned;
    else if (stall_F)
      pc_next = PC_F;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= BOOT;
    else
      state <= RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      PC_F <= RESET_PC;
    else if (!boot)
      PC_F <= pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fetch_count <= '0;
    else if (capture)
      fetch_count <= fetch_count + WIDTH'(1);
  end

  // The boot edge loads a bubble so decode never sees a half-initialised fetch.
  if_id_reg #(
    .WIDTH (WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .en         (!stall_D),
    .clr        (flush_D || boot),
    .instr_f    (instr_F),
    .pc_f       (PC_F),
    .pc_plus4_f (pc_plus4),
    .instr_d    (instr_D),
    .pc_d       (PC_D),
    .pc_plus4_d (PCplus4_D),
    .valid_d    (valid_D)
  );

endmodule

// File: tb/tb_top_fetch.sv
// Directed, table-driven bench for top_fetch with a PC-indexed imem model.
module tb_top_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_F, stall_D, flush_D, PCsrc_E;
  logic [31:0] PCtarget_E, instr_F;
  logic [31:0] PC_F, instr_D, PC_D, PCplus4_D, fetch_count;
  logic        valid_D;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign instr_F = mem(PC_F);

  top_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .PCsrc_E     (PCsrc_E),
    .PCtarget_E  (PCtarget_E),
    .instr_F     (instr_F),
    .PC_F        (PC_F),
    .instr_D     (instr_D),
    .PC_D        (PC_D),
    .PCplus4_D   (PCplus4_D),
    .valid_D     (valid_D),
    .fetch_count (fetch_count)
  );

  typedef struct {
    logic        sf, sd, fl, br;
    logic [31:0] tgt;
    logic [31:0] pc_f, instr, pc_d, pc4, cnt;
    logic        vld;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic sf, sd, fl, br, input logic [31:0] tgt,
                              input logic [31:0] pc_f, instr, pc_d, pc4,
                              input logic vld, input logic [31:0] cnt);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fl = fl; v.br = br; v.tgt = tgt;
    v.pc_f = pc_f; v.instr = instr; v.pc_d = pc_d; v.pc4 = pc4; v.vld = vld; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc_f, instr, pc_d, pc4,
                         input logic vld, input logic [31:0] cnt);
    chk({tag, ".PC_F"},        PC_F,        pc_f);
    chk({tag, ".instr_D"},     instr_D,     instr);
    chk({tag, ".PC_D"},        PC_D,        pc_d);
    chk({tag, ".PCplus4_D"},   PCplus4_D,   pc4);
    chk({tag, ".valid_D"},     {31'b0, valid_D}, {31'b0, vld});
    chk({tag, ".fetch_count"}, fetch_count, cnt);
  endtask

  task automatic drive(input logic sf, sd, fl, br, input logic [31:0] tgt);
    stall_F = sf; stall_D = sd; flush_D = fl; PCsrc_E = br; PCtarget_E = tgt;
  endtask

  initial begin
    // Each entry: inputs applied before an edge, outputs expected just after it.
    vecs[0]  = mk(0,0,0,0, 32'h0,          32'h0,          NOP,               32'h0,          32'h0,          0, 0); // BOOT edge
    vecs[1]  = mk(0,0,0,0, 32'h0,          32'h4,          mem(32'h0),        32'h0,          32'h4,          1, 1);
    vecs[2]  = mk(0,0,0,0, 32'h0,          32'h8,          mem(32'h4),        32'h4,          32'h8,          1, 2);
    vecs[3]  = mk(1,1,0,0, 32'h0,          32'h8,          mem(32'h4),        32'h4,          32'h8,          1, 2);
    vecs[4]  = mk(1,1,0,0, 32'h0,          32'h8,          mem(32'h4),        32'h4,          32'h8,          1, 2);
    vecs[5]  = mk(0,0,0,0, 32'h0,          32'hC,          mem(32'h8),        32'h8,          32'hC,          1, 3);
    vecs[6]  = mk(0,0,1,1, 32'h103,        32'h100,        NOP,               32'h0,          32'h0,          0, 3);
    vecs[7]  = mk(0,0,0,0, 32'h0,          32'h104,        mem(32'h100),      32'h100,        32'h104,        1, 4);
    vecs[8]  = mk(1,1,0,1, 32'h200,        32'h200,        mem(32'h100),      32'h100,        32'h104,        1, 4);
    vecs[9]  = mk(0,0,0,0, 32'h0,          32'h204,        mem(32'h200),      32'h200,        32'h204,        1, 5);
    vecs[10] = mk(0,0,1,1, 32'hFFFF_FFFE,  32'hFFFF_FFFC,  NOP,               32'h0,          32'h0,          0, 5);
    vecs[11] = mk(0,0,0,0, 32'h0,          32'h0,          mem(32'hFFFF_FFFC),32'hFFFF_FFFC,  32'h0,          1, 6);
    vecs[12] = mk(0,1,1,0, 32'h0,          32'h4,          NOP,               32'h0,          32'h0,          0, 6);
    vecs[13] = mk(1,0,0,0, 32'h0,          32'h4,          mem(32'h4),        32'h4,          32'h8,          1, 7);

    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, NOP, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].br, vecs[i].tgt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].pc_f, vecs[i].instr, vecs[i].pc_d,
              vecs[i].pc4, vecs[i].vld, vecs[i].cnt);
    end

    // Asynchronous reset between edges, then the boot sequence again.
    drive(0, 0, 0, 0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, NOP, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("reboot", 32'h0, NOP, 32'h0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    chk_all("rerun", 32'h4, mem(32'h0), 32'h0, 32'h4, 1, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
